ahb_s2_timer: RTL
=================

# ahb_s2_timer

AHB-Lite slave on interconnect slot s2 of the Cortex-M0 SoC. It provides a memory-mapped 32-bit down-counting timer with an 8-bit prescaler, one-shot or auto-reload mode, and a level interrupt routed to one of the core's IRQ inputs. It consumes the shared slave-side bus (`haddr_s`, `htrans_s`, …) and `hsel_s2`, and returns `hready_resp_s2`, `hresp_s2` and `hrdata_s2` to the interconnect.

## Interface
Parameters: none.

Ports:
- `HCLK` in 1 — single clock for the whole block.
- `HRESETn` in 1 — reset, asynchronous, active-low.
- `hsel_s2` in 1 — slave select from the interconnect.
- `haddr_s` in 32 — address; only `[11:2]` decoded.
- `htrans_s` in 2 — transfer type; `htrans_s[1]` = NONSEQ/SEQ.
- `hwrite_s` in 1 — 1 = write.
- `hsize_s` in 3 — transfer size; only `3'b010` (word) legal.
- `hwdata_s` in 32 — write data, valid in data phase.
- `HREADY` in 1 — bus-wide ready; qualifies the address phase.
- `hready_resp_s2` out 1 — slave ready.
- `hresp_s2` out 2 — `00` OKAY, `01` ERROR.
- `hrdata_s2` out 32 — read data.
- `irq` out 1 — level interrupt, `STATUS.flag & CTRL.IE`.

## Operation
Register map (word offset `haddr_s[3:2]`, with `haddr_s[11:4]` required to be 0):
- `0x0` CTRL, R/W. `[0]` EN, `[1]` IE, `[2]` AUTO, `[15:8]` PRESCALE; other bits read 0.
- `0x4` LOAD, R/W, 32 bits. A write also copies the value into VALUE and clears the prescaler.
- `0x8` VALUE, read-only. A write is an ERROR.
- `0xC` STATUS, `[0]` flag. Writing 1 clears it; writing 0 has no effect.

Bus state machine, states IDLE, ERR1, ERR2:
- **Address phase accepted** when `hsel_s2 & htrans_s[1] & HREADY`. On acceptance, latch offset, write flag and a legality flag.
- **Illegal accesses:** `hsize_s != 010`, `haddr_s[11:4] != 0`, or a write to VALUE.
- **Legal access:** zero-wait data phase. `hready_resp_s2=1`, `hresp_s2=00`. A write commits `hwdata_s` at the end of the data-phase cycle. A read drives the selected register on `hrdata_s2`, with the mux selected by the latched offset.
- **Illegal access:** IDLE→ERR1, with `hready_resp_s2=0`, `hresp_s2=01`. Then ERR1→ERR2, with `hready_resp_s2=1`, `hresp_s2=01`. Then ERR2→IDLE, or directly to ERR1 again if another illegal access is accepted in ERR2. No register is modified by an illegal access.
- **Outside a read data phase**, `hrdata_s2 = 0`.

Counter (updates only while EN=1):
- PRESCALE counter `pc` runs 0..PRESCALE and produces a `tick` when `pc == PRESCALE`, then wraps to 0. With EN=0, `pc` holds 0.
- On `tick` with VALUE≠0: VALUE decrements by 1.
- On `tick` with VALUE=0 (expiry): flag is set. If AUTO=1, VALUE reloads from LOAD. If AUTO=0, EN clears and VALUE stays 0.

Simultaneous events:
- A LOAD write in the same cycle as a tick: the LOAD value wins for VALUE, and a same-cycle expiry still sets flag.
- Flag set and STATUS clear in the same cycle: set wins.
- A CTRL write in the same cycle as an AUTO=0 expiry: the written EN wins.
- LOAD=0 with AUTO=1 expires on every tick.

## Timing
- **Reset values:** `hready_resp_s2=1`, `hresp_s2=00`, `hrdata_s2=0`, `irq=0`. CTRL, LOAD, VALUE, `pc` and flag are all 0, and the bus FSM is in IDLE.
- **Reset mid-transfer:** asserting `HRESETn` during a transfer aborts it immediately and returns to the reset state. There is no pending write.
- **Write latency:** a register write is visible to reads and to the counter from the cycle after its data phase.
- **Back-to-back transfers:** supported, including a read immediately following a write to the same register, which returns the new value.
- **Expiry period:** with PRESCALE=p and LOAD=N, the period is (N+1)·(p+1) cycles.
- **irq path:** `irq` is combinational from registered `flag` and `IE`. It rises in the cycle after the expiry tick.

## Test plan
- **Reset and idle reads:** reset, then read `0x0`, `0x4`, `0x8`, `0xC` → all return 0 with OKAY and zero wait; `irq=0`.
- **Auto-reload periodic interrupt:** write LOAD=3, then CTRL=`0x0007` (PRESCALE=0). VALUE reads 2,1,0 on successive cycles. `irq` rises 4 cycles after the CTRL data phase. After W1C of STATUS, `irq` falls, then re-rises 4 cycles after the preceding expiry.
- **One-shot with prescaler:** LOAD=1, CTRL=`0x0301` (PRESCALE=3, EN, no IE). Flag sets after 8 cycles, CTRL reads `0x0300` afterwards, VALUE stays 0, and `irq` stays 0.
- **Error responses:** a byte write to `0x4`, a write to `0x8`, and a read at `0x10` each produce 2 cycles of `hresp_s2=01`, with `hready_resp_s2` 0 then 1. Registers are unchanged.
- **Simultaneous set and clear:** W1C of STATUS lands on an expiry cycle → flag remains 1.
- **Reset during counting:** pulse `HRESETn` low mid-count → all registers and outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_s2_timer.sv
// ahb_s2_timer: AHB-Lite slave on slot s2 with a 32-bit down-counting timer,
//   8-bit prescaler, one-shot/auto-reload modes and a level interrupt.
// Latency: zero-wait data phase for legal accesses; writes take effect the next cycle.
// Backpressure: hready_resp_s2 is low only in the first cycle of a two-cycle ERROR.
//
// Ports:
//   HCLK, HRESETn                 clock, asynchronous active-low reset
//   hsel_s2, haddr_s, htrans_s,   address-phase inputs from the interconnect
//   hwrite_s, hsize_s, HREADY
//   hwdata_s                      write data (data phase)
//   hready_resp_s2, hresp_s2,     slave response and read data
//   hrdata_s2
//   irq                           level interrupt = STATUS.flag & CTRL.IE
//
// Register map (haddr_s[3:2], haddr_s[11:4] must be zero):
//   0x0 CTRL   [0] EN, [1] IE, [2] AUTO, [15:8] PRESCALE
//   0x4 LOAD   write also copies into VALUE and restarts the prescaler
//   0x8 VALUE  read-only, writes are answered with ERROR
//   0xC STATUS [0] flag, write 1 to clear

module ahb_s2_timer (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        hsel_s2,
  input  logic [31:0] haddr_s,
  input  logic [1:0]  htrans_s,
  input  logic        hwrite_s,
  input  logic [2:0]  hsize_s,
  input  logic [31:0] hwdata_s,
  input  logic        HREADY,
  output logic        hready_resp_s2,
  output logic [1:0]  hresp_s2,
  output logic [31:0] hrdata_s2,
  output logic        irq
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_VALUE  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } bus_state_e;

  bus_state_e state_q, state_d;

  // Latched address phase of a legal access, consumed in the following cycle.
  logic       dp_vld_q, dp_vld_d;
  logic       dp_wr_q,  dp_wr_d;
  logic [1:0] dp_off_q, dp_off_d;

  // Timer registers
  logic        en_q,    en_d;
  logic        ie_q,    ie_d;
  logic        auto_q,  auto_d;
  logic [7:0]  ps_q,    ps_d;
  logic [31:0] load_q,  load_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  pc_q,    pc_d;
  logic        flag_q,  flag_d;

  logic addr_acc;
  logic addr_illegal;
  logic wr_en;
  logic wr_ctrl;
  logic wr_load;
  logic wr_status;
  logic tick;
  logic expire;

  // Address bits that are never decoded, and the SEQ/NONSEQ distinction.
  logic unused_bits;
  assign unused_bits = ^{haddr_s[31:12], haddr_s[1:0], htrans_s[0]};

  // ---------------------------------------------------------------------------
  // Address phase decode
  // ---------------------------------------------------------------------------
  assign addr_acc     = hsel_s2 & htrans_s[1] & HREADY;
  assign addr_illegal = (hsize_s != 3'b010) |
                        (haddr_s[11:4] != 8'd0) |
                        (hwrite_s & (haddr_s[3:2] == OFF_VALUE));

  // ---------------------------------------------------------------------------
  // Bus FSM: IDLE serves legal accesses with zero wait; an illegal access runs
  // the two-cycle ERROR response ERR1 (not ready) -> ERR2 (ready).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dp_vld_d = 1'b0;
    dp_wr_d  = dp_wr_q;
    dp_off_d = dp_off_q;

    if (addr_acc && !addr_illegal) begin
      dp_vld_d = 1'b1;
      dp_wr_d  = hwrite_s;
      dp_off_d = haddr_s[3:2];
    end

    case (state_q)
      IDLE: begin
        if (addr_acc && addr_illegal) state_d = ERR1;
      end
      ERR1: begin
        state_d = ERR2;
      end
      ERR2: begin
        // A new illegal access accepted in ERR2 restarts the error sequence.
        if (addr_acc && addr_illegal) state_d = ERR1;
        else                          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign hready_resp_s2 = (state_q != ERR1);
  assign hresp_s2       = ((state_q == ERR1) || (state_q == ERR2)) ? 2'b01 : 2'b00;

  // Read data only during a legal read data phase, zero otherwise.
  always_comb begin
    hrdata_s2 = 32'd0;
    if (dp_vld_q && !dp_wr_q) begin
      case (dp_off_q)
        OFF_CTRL:   hrdata_s2 = {16'd0, ps_q, 5'd0, auto_q, ie_q, en_q};
        OFF_LOAD:   hrdata_s2 = load_q;
        OFF_VALUE:  hrdata_s2 = value_q;
        OFF_STATUS: hrdata_s2 = {31'd0, flag_q};
        default:    hrdata_s2 = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register writes (committed at the end of the data-phase cycle)
  // ---------------------------------------------------------------------------
  assign wr_en     = dp_vld_q & dp_wr_q;
  assign wr_ctrl   = wr_en & (dp_off_q == OFF_CTRL);
  assign wr_load   = wr_en & (dp_off_q == OFF_LOAD);
  assign wr_status = wr_en & (dp_off_q == OFF_STATUS);

  // ---------------------------------------------------------------------------
  // Counter. pc counts 0..PRESCALE; a tick is issued on the PRESCALE cycle.
  // If PRESCALE is lowered below pc while running, pc wraps through 255.
  // ---------------------------------------------------------------------------
  assign tick   = en_q & (pc_q == ps_q);
  assign expire = tick & (value_q == 32'd0);

  always_comb begin
    pc_d    = pc_q;
    value_d = value_q;
    en_d    = en_q;
    ie_d    = ie_q;
    auto_d  = auto_q;
    ps_d    = ps_q;
    load_d  = load_q;
    flag_d  = flag_q;

    if (!en_q || tick) pc_d = 8'd0;
    else               pc_d = pc_q + 8'd1;

    if (tick) begin
      if (value_q != 32'd0) value_d = value_q - 32'd1;
      else if (auto_q)      value_d = load_q;
    end

    // One-shot expiry stops the timer; a same-cycle CTRL write overrides it.
    if (expire && !auto_q) en_d = 1'b0;

    if (wr_ctrl) begin
      en_d   = hwdata_s[0];
      ie_d   = hwdata_s[1];
      auto_d = hwdata_s[2];
      ps_d   = hwdata_s[15:8];
    end

    // A LOAD write takes priority over the counter for VALUE and pc.
    if (wr_load) begin
      load_d  = hwdata_s;
      value_d = hwdata_s;
      pc_d    = 8'd0;
    end

    // Set beats clear when both land in the same cycle.
    if (wr_status && hwdata_s[0]) flag_d = 1'b0;
    if (expire)                   flag_d = 1'b1;
  end

  assign irq = flag_q & ie_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_off_q <= 2'd0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      auto_q   <= 1'b0;
      ps_q     <= 8'd0;
      load_q   <= 32'd0;
      value_q  <= 32'd0;
      pc_q     <= 8'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dp_vld_q <= dp_vld_d;
      dp_wr_q  <= dp_wr_d;
      dp_off_q <= dp_off_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      auto_q   <= auto_d;
      ps_q     <= ps_d;
      load_q   <= load_d;
      value_q  <= value_d;
      pc_q     <= pc_d;
      flag_q   <= flag_d;
    end
  end

endmodule
